// File: rtl/rev_addsub_seq.sv
// rev_addsub_seq: digit-serial reversible adder/subtractor handling DIGIT bits per clock,
// with a start/busy/done handshake, carry/borrow chaining and signed-overflow detection.
module rev_addsub_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout_brw,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || WIDTH % DIGIT != 0) begin : g_bad_params
        $error("rev_addsub_seq: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state;
    logic [WIDTH-1:0]       a_r, b_r;
    logic [CW-1:0]          cnt;
    logic                   md, k_r, a_msb, b_msb;
    logic [DIGIT-1:0]       ds;
    logic [WIDTH+DIGIT-1:0] cat;
    logic                   k, p, g;

    // Feynman gates fold mode into a (so ~a&b becomes the borrow generate) and undo it on the sum;
    // a Peres pair per bit produces propagate/generate and ripples the carry/borrow.
    always_comb begin
        ds = '0;
        k  = k_r;
        p  = 1'b0;
        g  = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            p     = (a_r[i] ^ md) ^ b_r[i];
            g     = (a_r[i] ^ md) & b_r[i];
            ds[i] = p ^ k ^ md;
            k     = (p & k) ^ g;
        end
    end

    // Operands shift down one digit per cycle; sum digits enter the result from the top.
    assign cat = {ds, result};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout_brw <= 1'b0;
            ovf      <= 1'b0;
            cnt      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            md       <= 1'b0;
            k_r      <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_r   <= a;
                    b_r   <= b;
                    md    <= mode;
                    k_r   <= cin;
                    a_msb <= a[WIDTH-1];
                    b_msb <= b[WIDTH-1];
                    cnt   <= '0;
                    state <= RUN;
                    busy  <= 1'b1;
                end
            end else begin
                a_r    <= a_r >> DIGIT;
                b_r    <= b_r >> DIGIT;
                result <= cat[WIDTH+DIGIT-1:DIGIT];
                k_r    <= k;
                cnt    <= cnt + CW'(1);
                if (cnt == CW'(N - 1)) begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    cout_brw <= k;
                    ovf      <= (md ? (a_msb != b_msb) : (a_msb == b_msb)) && (ds[DIGIT-1] != a_msb);
                end
            end
        end
    end
endmodule

// File: tb/tb_rev_addsub_seq.sv
// tb_rev_addsub_seq: directed and randomized checks of rev_addsub_seq across several
// WIDTH/DIGIT configurations against an arithmetic reference model.
module tb_rev_addsub_seq;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic [4:0]  busy_v, done_v, cout_v, ovf_v;
    logic [15:0] r0, r1, r2;
    logic [7:0]  r3, r4;
    int          runs = 0, fails = 0;
    localparam int WV[5] = '{16, 16, 16, 8, 8};

    always #5 clk = ~clk;

    rev_addsub_seq #(.WIDTH(16), .DIGIT(1)) u0 (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .a(a), .b(b), .cin(cin), .busy(busy_v[0]), .done(done_v[0]), .result(r0), .cout_brw(cout_v[0]), .ovf(ovf_v[0]));
    rev_addsub_seq #(.WIDTH(16), .DIGIT(4)) u1 (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .a(a), .b(b), .cin(cin), .busy(busy_v[1]), .done(done_v[1]), .result(r1), .cout_brw(cout_v[1]), .ovf(ovf_v[1]));
    rev_addsub_seq #(.WIDTH(16), .DIGIT(16)) u2 (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .a(a), .b(b), .cin(cin), .busy(busy_v[2]), .done(done_v[2]), .result(r2), .cout_brw(cout_v[2]), .ovf(ovf_v[2]));
    rev_addsub_seq #(.WIDTH(8), .DIGIT(1)) u3 (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .busy(busy_v[3]), .done(done_v[3]), .result(r3), .cout_brw(cout_v[3]), .ovf(ovf_v[3]));
    rev_addsub_seq #(.WIDTH(8), .DIGIT(4)) u4 (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .busy(busy_v[4]), .done(done_v[4]), .result(r4), .cout_brw(cout_v[4]), .ovf(ovf_v[4]));

    function automatic logic [15:0] res(input int i);
        return i == 0 ? r0 : i == 1 ? r1 : i == 2 ? r2 : i == 3 ? {8'h00, r3} : {8'h00, r4};
    endfunction

    // Reference: exact integer arithmetic, then wrap / range-check.
    task automatic model(input int w, input logic m, input logic [15:0] x, input logic [15:0] y, input logic c,
                         output logic [15:0] r, output logic co, output logic ov);
        longint lim = longint'(1) << w;
        longint ux = longint'(x) & (lim - 1), uy = longint'(y) & (lim - 1), cc = longint'(c);
        longint sx = ux >= lim / 2 ? ux - lim : ux, sy = uy >= lim / 2 ? uy - lim : uy;
        longint e  = m ? ux - uy - cc : ux + uy + cc;
        longint se = m ? sx - sy - cc : sx + sy + cc;
        r  = 16'(e & (lim - 1));
        co = m ? (e < 0) : (e >= lim);
        ov = (se < -(lim / 2)) || (se >= lim / 2);
    endtask

    task automatic launch(input logic m, input logic [15:0] x, input logic [15:0] y, input logic c);
        mode = m; a = x; b = y; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int bc);
        cyc = 0; bc = 0;
        while (!done_v[1] && cyc < 40) begin
            bc += int'(busy_v[1]);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        runs++;
        if ({busy_v, done_v, cout_v, ovf_v} !== 20'h0 || r1 !== 16'h0 || r0 !== 16'h0) begin
            fails++; $display("FAIL reset_state got busy=%b done=%b r1=%h cout=%b ovf=%b want all 0", busy_v, done_v, r1, cout_v, ovf_v);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add;
        int cyc, bc;
        launch(1'b0, 16'h1234, 16'h0FFF, 1'b0);
        wait_done(cyc, bc);
        runs++; if (cyc !== 4) begin fails++; $display("FAIL add_latency got %0d want 4", cyc); end
        runs++; if (bc !== 4) begin fails++; $display("FAIL add_busy_cycles got %0d want 4", bc); end
        runs++; if (busy_v[1] !== 1'b0) begin fails++; $display("FAIL add_busy_at_done got %b want 0", busy_v[1]); end
        runs++; if ({r1, cout_v[1], ovf_v[1]} !== {16'h2233, 2'b00}) begin
            fails++; $display("FAIL add_result got %h/%b/%b want 2233/0/0", r1, cout_v[1], ovf_v[1]);
        end
        @(negedge clk);
        runs++; if (done_v[1] !== 1'b0 || r1 !== 16'h2233) begin
            fails++; $display("FAIL add_done_pulse_hold got done=%b r=%h want 0/2233", done_v[1], r1);
        end
    endtask

    task automatic test_vectors;
        logic        tm[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] ta[4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [15:0] tb[4] = '{16'h0001, 16'h0000, 16'h0007, 16'h0001};
        logic        tc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [17:0] te[4] = '{{16'h0000, 2'b10}, {16'h8000, 2'b01}, {16'hFFFE, 2'b10}, {16'h7FFF, 2'b01}};
        int cyc, bc;
        for (int i = 0; i < 4; i++) begin
            launch(tm[i], ta[i], tb[i], tc[i]);
            wait_done(cyc, bc);
            runs++; if ({r1, cout_v[1], ovf_v[1]} !== te[i] || cyc !== 4) begin
                fails++; $display("FAIL vector%0d got %h/%b/%b cyc=%0d want %h/%b/%b cyc=4",
                                  i, r1, cout_v[1], ovf_v[1], cyc, te[i][17:2], te[i][1], te[i][0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore;
        int cyc;
        launch(1'b0, 16'h1234, 16'h0FFF, 1'b0);
        mode = 1'b1; a = 16'h0005; b = 16'h0007; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        while (!done_v[1] && cyc < 40) begin @(negedge clk); cyc++; end
        runs++; if (cyc !== 4 || {r1, cout_v[1], ovf_v[1]} !== {16'h2233, 2'b00}) begin
            fails++; $display("FAIL ignore_busy_start got %h/%b/%b cyc=%0d want 2233/0/0 cyc=4", r1, cout_v[1], ovf_v[1], cyc);
        end
        repeat (3) @(negedge clk);
        runs++; if (busy_v[1] !== 1'b0) begin fails++; $display("FAIL ignore_no_second_op busy got %b want 0", busy_v[1]); end
    endtask

    task automatic test_back_to_back;
        int cyc, bc;
        launch(1'b0, 16'hFFFF, 16'h0001, 1'b0);
        wait_done(cyc, bc);
        runs++; if ({r1, cout_v[1]} !== {16'h0000, 1'b1}) begin
            fails++; $display("FAIL b2b_first got %h/%b want 0000/1", r1, cout_v[1]);
        end
        launch(1'b1, 16'h0005, 16'h0007, 1'b0);
        wait_done(cyc, bc);
        runs++; if (cyc !== 4 || {r1, cout_v[1], ovf_v[1]} !== {16'hFFFE, 2'b10}) begin
            fails++; $display("FAIL b2b_second got %h/%b/%b cyc=%0d want fffe/1/0 cyc=4", r1, cout_v[1], ovf_v[1], cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cyc, bc, pulses;
        launch(1'b0, 16'h1234, 16'h0FFF, 1'b0);
        @(negedge clk);
        runs++; if (busy_v[1] !== 1'b1) begin fails++; $display("FAIL rst_mid_busy_before got %b want 1", busy_v[1]); end
        rst_n = 1'b0;
        #1;
        runs++; if ({busy_v, done_v, cout_v, ovf_v} !== 20'h0 || r1 !== 16'h0) begin
            fails++; $display("FAIL rst_mid_outputs got busy=%b done=%b r1=%h cout=%b ovf=%b want all 0", busy_v, done_v, r1, cout_v, ovf_v);
        end
        pulses = 0;
        repeat (2) begin @(negedge clk); pulses += int'(done_v[1]); end
        rst_n = 1'b1;
        repeat (6) begin @(negedge clk); pulses += int'(done_v[1]); end
        runs++; if (pulses !== 0) begin fails++; $display("FAIL rst_mid_no_done got %0d pulses want 0", pulses); end
        launch(1'b0, 16'h7FFF, 16'h0000, 1'b1);
        wait_done(cyc, bc);
        runs++; if (cyc !== 4 || {r1, cout_v[1], ovf_v[1]} !== {16'h8000, 2'b01}) begin
            fails++; $display("FAIL rst_mid_recover got %h/%b/%b cyc=%0d want 8000/0/1 cyc=4", r1, cout_v[1], ovf_v[1], cyc);
        end
    endtask

    task automatic test_random;
        logic [15:0] edge_vals[4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
        logic [15:0] er, got[5];
        logic        eco, eov, gco[5], gov[5];
        int          pulses[5];
        repeat (20) @(negedge clk);
        for (int n = 0; n < 1000; n++) begin
            launch(1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) == 0 ? edge_vals[$urandom_range(0, 3)] : 16'($urandom),
                   $urandom_range(0, 3) == 0 ? edge_vals[$urandom_range(0, 3)] : 16'($urandom),
                   1'($urandom_range(0, 1)));
            for (int i = 0; i < 5; i++) begin pulses[i] = 0; got[i] = '0; gco[i] = 1'b0; gov[i] = 1'b0; end
            for (int t = 0; t < 20; t++) begin
                for (int i = 0; i < 5; i++) if (done_v[i]) begin
                    pulses[i]++; got[i] = res(i); gco[i] = cout_v[i]; gov[i] = ovf_v[i];
                end
                @(negedge clk);
            end
            for (int i = 0; i < 5; i++) begin
                model(WV[i], mode, a, b, cin, er, eco, eov);
                runs++; if (pulses[i] !== 1 || got[i] !== er || gco[i] !== eco || gov[i] !== eov) begin
                    fails++; $display("FAIL random op%0d inst%0d m=%b a=%h b=%h c=%b got %h/%b/%b pulses=%0d want %h/%b/%b pulses=1",
                                      n, i, mode, a, b, cin, got[i], gco[i], gov[i], pulses[i], er, eco, eov);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_vectors;
        test_ignore;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", runs, fails);
        $finish;
    end
endmodule
